// File: rtl/mem_arbiter_if.sv
// Requester, memory and performance signals shared between mem_arbiter and its environment.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_valid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_be;
  logic [31:0]       d_rdata;
  logic              d_valid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;
  logic              f_stall;
  logic              d_stall;
  logic [31:0]       perf_istall;
  logic [31:0]       perf_conflict;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output f_stall, d_stall, perf_istall, perf_conflict
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  f_stall, d_stall, perf_istall, perf_conflict
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-port memory; data wins ties; optional counters under MEM_ARBITER_PERF_EN.
// Latency: issue in the request cycle when idle, completion pulse MEM_LAT cycles after issue.
// Backpressure: requesters hold req and see f_stall/d_stall until their completion cycle.
module mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 32
) (
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              d_we_q, d_we_nxt;
  logic              issue_i, issue_d;
  logic [ADDR_W-1:0] addr_mux;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      d_we_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      d_we_q <= d_we_nxt;
    end
  end

  // The completing port is never re-granted in its own completion cycle.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    d_we_nxt     = d_we_q;
    issue_i      = 1'b0;
    issue_d      = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_rdata = 32'd0;
    bus.d_valid  = 1'b0;
    bus.d_rdata  = 32'd0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (bus.d_req)       issue_d = 1'b1;
          else if (bus.if_req) issue_i = 1'b1;
        end
        BUSY_I: begin
          cnt_nxt = 4'(cnt + 4'd1);
          if (cnt == LAT) begin
            bus.if_valid = 1'b1;
            bus.if_rdata = bus.mem_rdata;
            state_nxt    = IDLE;
            cnt_nxt      = 4'd0;
            if (bus.d_req) issue_d = 1'b1;
          end
        end
        BUSY_D: begin
          cnt_nxt = 4'(cnt + 4'd1);
          if (cnt == LAT) begin
            bus.d_valid = 1'b1;
            bus.d_rdata = d_we_q ? 32'd0 : bus.mem_rdata;
            state_nxt   = IDLE;
            cnt_nxt     = 4'd0;
            if (bus.if_req) issue_i = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (issue_d) begin
        state_nxt = BUSY_D;
        cnt_nxt   = 4'd1;
        d_we_nxt  = bus.d_we;
      end
      if (issue_i) begin
        state_nxt = BUSY_I;
        cnt_nxt   = 4'd1;
      end
    end
  end

  always_comb begin
    addr_mux      = issue_d ? bus.d_addr : (issue_i ? bus.if_addr : '0);
    bus.mem_addr  = addr_mux;
    bus.mem_en    = issue_i | issue_d;
    bus.mem_we    = issue_d & bus.d_we;
    bus.mem_wdata = issue_d ? bus.d_wdata : 32'd0;
    bus.mem_be    = issue_d ? bus.d_be : 4'd0;
    bus.f_stall   = ~reset & bus.if_req & ~bus.if_valid;
    bus.d_stall   = ~reset & bus.d_req & ~bus.d_valid;
  end

`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] istall_q, conflict_q;
  logic        fetch_owner;

  assign fetch_owner = issue_i | ((state == BUSY_I) & ~bus.if_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      istall_q   <= 32'd0;
      conflict_q <= 32'd0;
    end else begin
      if (bus.f_stall) istall_q <= istall_q + 32'd1;
      if (bus.if_req & bus.d_req & ~fetch_owner) conflict_q <= conflict_q + 32'd1;
    end
  end

  assign bus.perf_istall   = istall_q;
  assign bus.perf_conflict = conflict_q;
`else
  assign bus.perf_istall   = 32'd0;
  assign bus.perf_conflict = 32'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: MEM_LAT=2 instance (bus_a) for the main table and corners, MEM_LAT=1 instance (bus_b).
module tb_mem_arbiter;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  mem_arbiter_if #(.ADDR_W(32)) bus_a ();
  mem_arbiter_if #(.ADDR_W(32)) bus_b ();

  mem_arbiter #(.MEM_LAT(2), .ADDR_W(32)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  mem_arbiter #(.MEM_LAT(1), .ADDR_W(32)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] mem_rdata;
    logic        x_mem_en;
    logic        x_mem_we;
    logic [31:0] x_mem_addr;
    logic [31:0] x_mem_wdata;
    logic [3:0]  x_mem_be;
    logic        x_if_valid;
    logic [31:0] x_if_rdata;
    logic        x_d_valid;
    logic [31:0] x_d_rdata;
    logic        x_f_stall;
    logic        x_d_stall;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input vec_t v);
    bus_a.if_req    = v.if_req;
    bus_a.if_addr   = v.if_addr;
    bus_a.d_req     = v.d_req;
    bus_a.d_we      = v.d_we;
    bus_a.d_addr    = v.d_addr;
    bus_a.d_wdata   = v.d_wdata;
    bus_a.d_be      = v.d_be;
    bus_a.mem_rdata = v.mem_rdata;
  endtask

  task automatic idle_a();
    bus_a.if_req = 1'b0; bus_a.if_addr = 32'd0; bus_a.d_req = 1'b0; bus_a.d_we = 1'b0;
    bus_a.d_addr = 32'd0; bus_a.d_wdata = 32'd0; bus_a.d_be = 4'd0; bus_a.mem_rdata = 32'd0;
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    n_total = 0;
    n_pass = 0;
    idle_a();
    bus_b.if_req = 1'b0; bus_b.if_addr = 32'd0; bus_b.d_req = 1'b0; bus_b.d_we = 1'b0;
    bus_b.d_addr = 32'd0; bus_b.d_wdata = 32'd0; bus_b.d_be = 4'd0; bus_b.mem_rdata = 32'd0;

    //                ifr   if_addr      dr    dwe   d_addr      d_wdata       be     mem_rdata      en    we    mem_addr    mem_wdata     mbe    iv    if_rdata       dv    d_rdata        fs    ds
    vecs[0]  = '{1'b1, 32'h3000, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 32'h24080005, 1'b1, 1'b0, 32'h3000, 32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0};
    vecs[1]  = '{1'b1, 32'h3000, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 32'h24080005, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0};
    vecs[2]  = '{1'b1, 32'h3000, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 32'h24080005, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 32'h24080005, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 32'h24080005, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h3004, 1'b1, 1'b0, 32'h10, 32'h0,        4'h0, 32'h11112222, 1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1};
    vecs[5]  = '{1'b1, 32'h3004, 1'b1, 1'b0, 32'h10, 32'h0,        4'h0, 32'h11112222, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1};
    vecs[6]  = '{1'b1, 32'h3004, 1'b1, 1'b0, 32'h10, 32'h0,        4'h0, 32'h11112222, 1'b1, 1'b0, 32'h3004, 32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 32'h11112222, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 32'h3004, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 32'h11112222, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0};
    vecs[8]  = '{1'b1, 32'h3004, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 32'h11112222, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 32'h11112222, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 32'h11112222, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 32'hCAFEF00D, 1'b1, 1'b1, 32'h20,   32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
    vecs[11] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
    vecs[12] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0};
    vecs[13] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};

    // Reset state
    #2;
    chk("rst mem_en", {31'd0, bus_a.mem_en}, 32'd0);
    chk("rst if_valid", {31'd0, bus_a.if_valid}, 32'd0);
    chk("rst d_valid", {31'd0, bus_a.d_valid}, 32'd0);
    chk("rst perf_istall", bus_a.perf_istall, 32'd0);
    chk("rst perf_conflict", bus_a.perf_conflict, 32'd0);
    repeat (2) next_cycle();
    reset = 1'b0;

    // Single fetch, simultaneous request, store
    for (int i = 0; i < 14; i++) begin
      drive_a(vecs[i]);
      @(negedge clk);
      chk($sformatf("row%0d mem_en", i),    {31'd0, bus_a.mem_en},   {31'd0, vecs[i].x_mem_en});
      chk($sformatf("row%0d mem_we", i),    {31'd0, bus_a.mem_we},   {31'd0, vecs[i].x_mem_we});
      chk($sformatf("row%0d mem_addr", i),  bus_a.mem_addr,          vecs[i].x_mem_addr);
      chk($sformatf("row%0d mem_wdata", i), bus_a.mem_wdata,         vecs[i].x_mem_wdata);
      chk($sformatf("row%0d mem_be", i),    {28'd0, bus_a.mem_be},   {28'd0, vecs[i].x_mem_be});
      chk($sformatf("row%0d if_valid", i),  {31'd0, bus_a.if_valid}, {31'd0, vecs[i].x_if_valid});
      chk($sformatf("row%0d if_rdata", i),  bus_a.if_rdata,          vecs[i].x_if_rdata);
      chk($sformatf("row%0d d_valid", i),   {31'd0, bus_a.d_valid},  {31'd0, vecs[i].x_d_valid});
      chk($sformatf("row%0d d_rdata", i),   bus_a.d_rdata,           vecs[i].x_d_rdata);
      chk($sformatf("row%0d f_stall", i),   {31'd0, bus_a.f_stall},  {31'd0, vecs[i].x_f_stall});
      chk($sformatf("row%0d d_stall", i),   {31'd0, bus_a.d_stall},  {31'd0, vecs[i].x_d_stall});
      next_cycle();
    end

`ifdef MEM_ARBITER_PERF_EN
    chk("perf_istall after table", bus_a.perf_istall, 32'd6);
    chk("perf_conflict after table", bus_a.perf_conflict, 32'd2);
`else
    chk("perf_istall tied off", bus_a.perf_istall, 32'd0);
    chk("perf_conflict tied off", bus_a.perf_conflict, 32'd0);
`endif

    // Sustained contention: D, I, D, I ... every second cycle
    for (int c = 0; c < 12; c++) begin
      bus_a.if_req = 1'b1; bus_a.if_addr = 32'h200;
      bus_a.d_req = 1'b1; bus_a.d_we = 1'b0; bus_a.d_addr = 32'h100;
      bus_a.mem_rdata = 32'hA5A50000 | 32'(c);
      @(negedge clk);
      chk($sformatf("cont%0d mem_en", c), {31'd0, bus_a.mem_en}, (c % 2 == 0) ? 32'd1 : 32'd0);
      if (c % 2 == 0) begin
        chk($sformatf("cont%0d mem_addr", c), bus_a.mem_addr, ((c / 2) % 2 == 0) ? 32'h100 : 32'h200);
      end
      if (c > 0 && c % 2 == 0) begin
        chk($sformatf("cont%0d d_valid", c), {31'd0, bus_a.d_valid}, (((c / 2) - 1) % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("cont%0d if_valid", c), {31'd0, bus_a.if_valid}, (((c / 2) - 1) % 2 == 0) ? 32'd0 : 32'd1);
      end else begin
        chk($sformatf("cont%0d no valid", c), {30'd0, bus_a.d_valid, bus_a.if_valid}, 32'd0);
      end
      next_cycle();
    end

    reset = 1'b1;
    idle_a();
    repeat (2) next_cycle();
    reset = 1'b0;

    // Reset in cycle 1 of a fetch
    bus_a.if_req = 1'b1; bus_a.if_addr = 32'h40; bus_a.mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("rstmid issue mem_en", {31'd0, bus_a.mem_en}, 32'd1);
    chk("rstmid issue mem_addr", bus_a.mem_addr, 32'h40);
    next_cycle();
    reset = 1'b1;
    #1;
    chk("rstmid mem_en", {31'd0, bus_a.mem_en}, 32'd0);
    chk("rstmid mem_addr", bus_a.mem_addr, 32'd0);
    chk("rstmid f_stall", {31'd0, bus_a.f_stall}, 32'd0);
    chk("rstmid if_valid", {31'd0, bus_a.if_valid}, 32'd0);
    chk("rstmid if_rdata", bus_a.if_rdata, 32'd0);
    chk("rstmid perf_istall", bus_a.perf_istall, 32'd0);
    next_cycle();
    bus_a.if_req = 1'b0;
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("postrst%0d if_valid", c), {31'd0, bus_a.if_valid}, 32'd0);
      chk($sformatf("postrst%0d mem_en", c), {31'd0, bus_a.mem_en}, 32'd0);
      next_cycle();
    end
    // Immediate issue shows the arbiter is back in IDLE
    bus_a.d_req = 1'b1; bus_a.d_we = 1'b0; bus_a.d_addr = 32'h80; bus_a.mem_rdata = 32'h0BADF00D;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("postrst load%0d mem_en", c), {31'd0, bus_a.mem_en}, (c == 0) ? 32'd1 : 32'd0);
      chk($sformatf("postrst load%0d d_valid", c), {31'd0, bus_a.d_valid}, (c == 2) ? 32'd1 : 32'd0);
      if (c == 2) chk("postrst load d_rdata", bus_a.d_rdata, 32'h0BADF00D);
      next_cycle();
    end
    idle_a();

    // MEM_LAT=1: back-to-back fetches, one idle re-issue gap
    for (int c = 0; c < 4; c++) begin
      bus_b.if_req = 1'b1; bus_b.if_addr = 32'h500; bus_b.mem_rdata = 32'h600D0001;
      @(negedge clk);
      chk($sformatf("lat1 c%0d mem_en", c), {31'd0, bus_b.mem_en}, (c == 0 || c == 2) ? 32'd1 : 32'd0);
      chk($sformatf("lat1 c%0d if_valid", c), {31'd0, bus_b.if_valid}, (c == 1 || c == 3) ? 32'd1 : 32'd0);
      chk($sformatf("lat1 c%0d f_stall", c), {31'd0, bus_b.f_stall}, (c == 1 || c == 3) ? 32'd0 : 32'd1);
      if (c == 1 || c == 3) chk($sformatf("lat1 c%0d if_rdata", c), bus_b.if_rdata, 32'h600D0001);
      next_cycle();
    end
    bus_b.if_req = 1'b0;
    @(negedge clk);
    chk("lat1 idle mem_en", {31'd0, bus_b.mem_en}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one single-port synchronous unified memory between two requesters: the fetch stage (instruction port) and the memory stage (data port).
- Sequences each access over a fixed memory latency.
- Returns read data and a one-cycle completion pulse to the requester.
- Generates the fetch stall (`f_stall`, wired to F's stall input) and the data stall for the pipeline hazard logic.

Parameters:
- MEM_LAT, 2, cycles from issue to read data valid; legal range 1..15.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until `if_valid`.
- if_addr  in  ADDR_W  fetch address (PC).
- if_rdata  out  32  instruction word; valid only while `if_valid`.
- if_valid  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held high until `d_valid`.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  32  store data.
- d_be  in  4  store byte enables.
- d_rdata  out  32  load data; valid only while `d_valid`; 0 on store completion.
- d_valid  out  1  one-cycle data completion pulse.
- mem_en  out  1  memory issue strobe; one cycle per access.
- mem_we  out  1  memory write enable; qualified by `mem_en`.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  32  memory read data; valid MEM_LAT cycles after issue.
- f_stall  out  1  `if_req & ~if_valid`.
- d_stall  out  1  `d_req & ~d_valid`.
- perf_istall  out  32  fetch stall cycle count (optional feature).
- perf_conflict  out  32  conflict cycle count (optional feature).

Behaviour:
- **Reset (asynchronous, immediate):**
  - State = IDLE, latency counter = 0, grant owner = none.
  - All outputs 0, including perf counters.
- **FSM states:** IDLE, BUSY_I, BUSY_D.
- **IDLE:**
  - If `d_req`, issue data access this cycle and go to BUSY_D.
  - Else if `if_req`, issue fetch this cycle and go to BUSY_I.
  - Data wins ties because it belongs to the older instruction.
- **Issue cycle t:**
  - `mem_en` = 1.
  - `mem_we` / `mem_addr` / `mem_wdata` / `mem_be` are driven combinationally from the granted requester.
  - `mem_we` = 0 and `mem_be` = 4'b0000 for fetches.
  - Counter loads 1.
- **BUSY_x:**
  - Counter increments each cycle.
  - Completion cycle is t+MEM_LAT (counter == MEM_LAT).
  - In the completion cycle, `x_valid` = 1 and `x_rdata` = `mem_rdata` (0 for a store).
- **Completion-cycle arbitration:**
  - The completing requester is excluded.
  - If the other requester is pending, issue it in the same cycle (`mem_en` = 1) and enter its BUSY state.
  - Otherwise return to IDLE.
  - This gives back-to-back issue with no bubble and alternation under sustained contention; neither port starves.
- **Outside the issue cycle:** `mem_en` = 0 and `mem_*` outputs hold 0.
- **Request rules:**
  - Address and data are sampled only at issue; later changes before completion are ignored.
  - Dropping `req` before `valid` is illegal and not checked.
- **Stalls:** `f_stall` / `d_stall` are combinational and high on every requesting cycle except the completion cycle.
- **MEM_LAT = 1:** issue at t, complete at t+1. Consecutive same-port requests see a 1-cycle gap: IDLE re-issues on the cycle after completion.
- **Reset mid-access:** access is abandoned with no valid pulse. The memory may still complete a write already issued.

Optional Feature:
Macro MEM_ARBITER_PERF_EN.
- **Defined:**
  - `perf_istall` increments each cycle `f_stall` = 1.
  - `perf_conflict` increments each cycle `if_req & d_req` while a grant is not going to fetch.
  - Both are 32-bit, wrap at 2^32, and clear only on reset.
- **Undefined:** both ports tied to 0 and no counter flops are inferred.

Test Plan:
1. **Single fetch** (MEM_LAT=2): `if_req`=1, `if_addr`=0x00003000 at cycle 0; memory returns 0x24080005.
   - Required: `mem_en`=1 at cycle 0 with `mem_addr`=0x3000.
   - Required: `if_valid`=1 and `if_rdata`=0x24080005 at cycle 2.
   - Required: `f_stall`=1 at cycles 0-1 and 0 at cycle 2.
2. **Simultaneous request:** `if_req` and `d_req` (load, 0x0000_0010) both asserted at cycle 0.
   - Required: data issued at cycle 0, `d_valid` at cycle 2.
   - Required: fetch issued at cycle 2 (`mem_en`=1, same cycle), `if_valid` at cycle 4.
   - Required: `perf_conflict`=2 with the macro defined.
3. **Store:** `d_we`=1, `d_addr`=0x20, `d_wdata`=0xDEADBEEF, `d_be`=4'b1111.
   - Required: `mem_we`=1 with these values in the issue cycle only.
   - Required: `d_valid` pulse 2 cycles later with `d_rdata`=0.
4. **Sustained contention** (both requesters held high 12 cycles, MEM_LAT=2).
   - Required: grants alternate D, I, D, I, …, with `mem_en` high every 2nd cycle.
5. **Reset mid-access:** reset asserted at cycle 1 of a fetch.
   - Required: all outputs 0 immediately.
   - Required: no `if_valid`, and state is IDLE after release.
6. **MEM_LAT=1 build, back-to-back fetches:**
   - Required: completions at cycles 1 and 3.
   - Required: `f_stall`=0 only at cycles 1 and 3.
